// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues sequential word-aligned fetch requests,
// buffers returned instructions in a small in-order prefetch queue, and
// delivers them to decode under stall. A taken branch flushes the queue and
// arranges for responses already in flight to be discarded on arrival.
module fetch_prefetch_unit #(
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        taken_branch_i,
  input  logic [31:0] new_pc_i,
  input  logic        stall_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  // Pointers carry one extra bit so a full queue is distinct from an empty one.
  localparam int PW = AW + 1;
  localparam int CW = $clog2(QUEUE_DEPTH + MAX_OUTSTANDING + 1) + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] pending_q, pending_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          rst_dly_q;

  logic [31:0]            pc_q    [QUEUE_DEPTH];
  logic [31:0]            pc_d    [QUEUE_DEPTH];
  logic [31:0]            instr_q [QUEUE_DEPTH];
  logic [31:0]            instr_d [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] filled_q, filled_d;

  logic [PW-1:0] occ;
  logic [CW-1:0] outstanding;
  logic [AW-1:0] head_idx, alloc_idx, fill_idx;
  logic          issue, rsp, pop, rsp_fills;

  // Request/deliver handshakes derived from registered state.
  always_comb begin
    head_idx    = head_q[AW-1:0];
    alloc_idx   = alloc_q[AW-1:0];
    fill_idx    = fill_q[AW-1:0];
    occ         = alloc_q - head_q;
    outstanding = pending_q + drop_cnt_q;

    // Requests stay quiet in reset, in the cycle after it, and on a redirect.
    imem_req_valid_o = !rst_i && !rst_dly_q && !taken_branch_i &&
                       (occ != PW'(QUEUE_DEPTH)) &&
                       (outstanding < CW'(MAX_OUTSTANDING));
    imem_req_addr_o  = fetch_pc_q;
    issue            = imem_req_valid_o && imem_req_ready_i;

    rsp       = imem_rsp_valid_i && !rst_i;
    rsp_fills = rsp && (drop_cnt_q == '0);

    valid_o = filled_q[head_idx] && !taken_branch_i && !rst_i;
    pc_o    = valid_o ? pc_q[head_idx]    : 32'h0;
    instr_o = valid_o ? instr_q[head_idx] : 32'h0;
    pop     = valid_o && !stall_i;
  end

  // Next-state for pointers, counters and queue entries.
  always_comb begin
    head_d     = head_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    fetch_pc_d = fetch_pc_q;
    pending_d  = pending_q;
    drop_cnt_d = drop_cnt_q;
    filled_d   = filled_q;
    pc_d       = pc_q;
    instr_d    = instr_q;

    if (taken_branch_i) begin
      // Everything live becomes squashed; a response arriving right now
      // consumes one of those squashed slots immediately.
      head_d     = '0;
      alloc_d    = '0;
      fill_d     = '0;
      filled_d   = '0;
      fetch_pc_d = new_pc_i & ~32'd3;
      drop_cnt_d = drop_cnt_q + pending_q - CW'(rsp);
      pending_d  = '0;
    end else begin
      if (issue) begin
        pc_d[alloc_idx]     = fetch_pc_q;
        filled_d[alloc_idx] = 1'b0;
        alloc_d             = alloc_q + PW'(1);
        fetch_pc_d          = fetch_pc_q + 32'd4;
      end
      if (rsp) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          instr_d[fill_idx]  = imem_rsp_data_i;
          filled_d[fill_idx] = 1'b1;
          fill_d             = fill_q + PW'(1);
        end
      end
      if (pop) begin
        filled_d[head_idx] = 1'b0;
        head_d             = head_q + PW'(1);
      end
      pending_d = pending_q + CW'(issue) - CW'(rsp_fills);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q     <= '0;
      alloc_q    <= '0;
      fill_q     <= '0;
      fetch_pc_q <= RESET_PC;
      pending_q  <= '0;
      drop_cnt_q <= '0;
      filled_q   <= '0;
    end else begin
      head_q     <= head_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
      drop_cnt_q <= drop_cnt_d;
      filled_q   <= filled_d;
    end
    rst_dly_q <= rst_i;
  end

  // Entry payload storage; validity is tracked by filled_q, so no reset.
  always_ff @(posedge clk_i) begin
    pc_q    <= pc_d;
    instr_q <= instr_d;
  end

endmodule
